aes_decipher_block: RTL and testbench
=====================================

Name: aes_decipher_block

Overview:
Iterative AES-128 inverse cipher: the decrypt counterpart of the existing encryption block, for the ECB/CBC-decrypt path we add next to the CTR datapath.
- Takes a 128-bit ciphertext and returns the plaintext.
- Pulls round keys from the existing KeyGen through the round/roundKey interface, in reverse order (10 down to 0).
- Does InvSubBytes one 32-bit word per cycle through an external inverse S-box port.
- The top level selects between this block and the encryptor using the same ready/next handshake.

Parameters:
NUM_ROUNDS, 10, AES-128 round count; only 10 is supported, other values are illegal.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low.
next  input  1  start pulse; sampled only while ready=1.
block  input  128  ciphertext; sampled on the accepted next.
roundKey  input  128  round key for the index on round; valid combinationally in the same cycle.
round  output  4  round key index requested from KeyGen.
invSBoxRequest  output  32  four bytes to the inverse S-box.
invSBoxResponse  input  32  bytewise InvSBox(invSBoxRequest); combinational.
newBlock  output  128  plaintext; held until the next completion.
ready  output  1  1 = idle, result valid or no job; 0 = busy.

Behaviour:
- Byte order follows FIPS-197: block[127:120] is state byte 0, column-major. Word w occupies bits [127-32w -: 32].
- Reset, asynchronous and valid at any time including mid-operation:
  - ready=1, newBlock=0, round=0, invSBoxRequest=0.
  - FSM goes to IDLE; any job in flight is dropped and produces no output.
- FSM states: IDLE, INIT, SBOX, MAIN.
- IDLE:
  - round=0.
  - On next=1 at edge N: state<=block, rctr<=10, ready<=0, go to INIT.
- INIT (round=10):
  - state <= InvShiftRows(state ^ roundKey).
  - rctr<=9, wctr<=0, go to SBOX.
- SBOX (round=rctr), 4 cycles:
  - invSBoxRequest = state word wctr; that word <= invSBoxResponse; wctr increments.
  - After wctr=3, go to MAIN.
- MAIN (round=rctr):
  - rctr>0: state <= InvShiftRows(InvMixColumns(state ^ roundKey)); rctr decrements; wctr<=0; go to SBOX.
  - rctr=0: newBlock <= state ^ roundKey; ready<=1; go to IDLE.
- Latency: accepted next at edge N gives ready=1 and a valid newBlock after edge N+51 (1 INIT cycle + 10 x (4 SBOX + 1 MAIN)).
- next while ready=0 is ignored; block is not re-sampled.
- next in the same cycle that completion is registered is ignored; a new job is accepted no earlier than the first IDLE cycle.
- next held high continuously starts back-to-back jobs, each 52 cycles apart (edge to edge).
- invSBoxRequest outside SBOX: drives 0.
- newBlock is not cleared when a new job starts; it changes only at completion.
- InvMixColumns per column uses GF(2^8) multiplies by {0e,0b,0d,09}, reduction polynomial 0x11b; all byte arithmetic is 8-bit.

Decomposition:
- Package aes_dec_pkg:
  - FSM state encodings (2-bit).
  - AES128_ROUNDS = 10.
  - Functions xtime, gmul9, gmul11, gmul13, gmul14, inv_mix_column(32), inv_shift_rows(128).
- Sub-module inv_sub_box:
  - Combinational, 4 parallel 256-entry inverse S-box ROMs.
  - Instantiated by the parent top next to this block, mirroring SubBox; it is not instantiated inside this block.

Test Plan:
- FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, block 69c4e0d86a7b0430d8cdb78070b4c55a, pulse next -> ready low 51 cycles, then newBlock=00112233445566778899aabbccddeeff, ready=1.
- FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, block 3925841d02dc09fbdc118597196a0b32 -> newBlock=3243f6a8885a308d313198a2e0370734.
- Round sequencing: monitor round -> 10 for 1 cycle, then 9..0 for 5 cycles each, then 0 in IDLE. invSBoxRequest is nonzero only during the SBOX cycles (bench checks against the reference model).
- Busy next: pulse next with a different block at cycle N+20 -> ignored; result still matches the first block; completion still at N+51.
- Reset mid-op: assert reset at N+30 for 2 cycles -> ready=1, newBlock=0, round=0 immediately. A fresh C.1 job then completes correctly.
- Back-to-back next held high with blocks App. B then C.1 -> two correct results, second ready rise 52 cycles after the first. newBlock holds the App. B plaintext until the second completion.

Source files
------------

// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the AES-128 inverse cipher.
package aes_dec_pkg;

    localparam int AES128_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        SBOX = 2'd2,
        MAIN = 2'd3
    } decState_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul9(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b;
    endfunction

    function automatic logic [7:0] gmul11(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b2 ^ b;
    endfunction

    function automatic logic [7:0] gmul13(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b4 ^ b;
    endfunction

    function automatic logic [7:0] gmul14(input logic [7:0] b);
        logic [7:0] b2, b4, b8;
        b2 = xtime(b);
        b4 = xtime(b2);
        b8 = xtime(b4);
        return b8 ^ b4 ^ b2;
    endfunction

    // Column word holds row 0 in its most significant byte.
    function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        return {gmul14(a0) ^ gmul11(a1) ^ gmul13(a2) ^ gmul9(a3),
                gmul9(a0)  ^ gmul14(a1) ^ gmul11(a2) ^ gmul13(a3),
                gmul13(a0) ^ gmul9(a1)  ^ gmul14(a2) ^ gmul11(a3),
                gmul11(a0) ^ gmul13(a1) ^ gmul9(a2)  ^ gmul14(a3)};
    endfunction

    // Row r of the column-major state rotates right by r byte positions.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                r[127 - 8 * (4 * c + row) -: 8] = s[127 - 8 * (4 * ((c - row + 4) % 4) + row) -: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/inv_sub_box.sv
// Four parallel AES inverse S-box lookups, one per byte of a 32-bit word.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows input within the same cycle.
module inv_sub_box (
    input  logic [31:0] request,
    output logic [31:0] response
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    for (genvar i = 0; i < 4; i++) begin : gLane
        assign response[8 * i +: 8] = INV_SBOX[request[8 * i +: 8]];
    end

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128 inverse cipher; InvSubBytes one word per cycle via an external S-box.
// Latency: 52 cycles accept-to-accept; result and ready register 51 edges after the accepted next.
// Backpressure: ready=0 while busy; next is ignored until the first IDLE cycle after completion.
module aes_decipher_block
    import aes_dec_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic [127:0] block,
    input  logic [127:0] roundKey,
    output logic [3:0]   round,
    output logic [31:0]  invSBoxRequest,
    input  logic [31:0]  invSBoxResponse,
    output logic [127:0] newBlock,
    output logic         ready
);

    if (NUM_ROUNDS != AES128_ROUNDS) begin : gBadRounds
        $error("aes_decipher_block supports only NUM_ROUNDS = 10");
    end

    decState_t    fsm;
    logic [127:0] state;
    logic [127:0] keyed;
    logic [3:0]   rctr;
    logic [1:0]   wctr;

    assign keyed = state ^ roundKey;
    assign round = rctr;

    always_comb begin
        invSBoxRequest = '0;
        if (fsm == SBOX) begin
            case (wctr)
                2'd0: invSBoxRequest = state[127:96];
                2'd1: invSBoxRequest = state[95:64];
                2'd2: invSBoxRequest = state[63:32];
                default: invSBoxRequest = state[31:0];
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fsm      <= IDLE;
            state    <= '0;
            rctr     <= '0;
            wctr     <= '0;
            newBlock <= '0;
            ready    <= 1'b1;
        end else begin
            case (fsm)
                IDLE: begin
                    if (next) begin
                        state <= block;
                        rctr  <= 4'(NUM_ROUNDS);
                        ready <= 1'b0;
                        fsm   <= INIT;
                    end
                end
                INIT: begin
                    state <= inv_shift_rows(keyed);
                    rctr  <= rctr - 4'd1;
                    wctr  <= '0;
                    fsm   <= SBOX;
                end
                SBOX: begin
                    case (wctr)
                        2'd0: state[127:96] <= invSBoxResponse;
                        2'd1: state[95:64]  <= invSBoxResponse;
                        2'd2: state[63:32]  <= invSBoxResponse;
                        default: state[31:0] <= invSBoxResponse;
                    endcase
                    wctr <= wctr + 2'd1;
                    if (wctr == 2'd3) begin
                        fsm <= MAIN;
                    end
                end
                MAIN: begin
                    if (rctr != 4'd0) begin
                        state <= inv_shift_rows({inv_mix_column(keyed[127:96]),
                                                 inv_mix_column(keyed[95:64]),
                                                 inv_mix_column(keyed[63:32]),
                                                 inv_mix_column(keyed[31:0])});
                        rctr  <= rctr - 4'd1;
                        wctr  <= '0;
                        fsm   <= SBOX;
                    end else begin
                        // Final AddRoundKey with key 0; rctr stays 0 so round reads 0 in IDLE.
                        newBlock <= keyed;
                        ready    <= 1'b1;
                        fsm      <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aes_decipher_block.sv
// Scoreboard bench for aes_decipher_block with a behavioural KeyGen and the inverse S-box alongside.
module tb_aes_decipher_block;

    logic         clk = 1'b0;
    logic         reset;
    logic         next;
    logic [127:0] block;
    logic [127:0] roundKey;
    logic [3:0]   round;
    logic [31:0]  invSBoxRequest;
    logic [31:0]  invSBoxResponse;
    logic [127:0] newBlock;
    logic         ready;

    always #5 clk = ~clk;

    aes_decipher_block dut (
        .clk             (clk),
        .reset           (reset),
        .next            (next),
        .block           (block),
        .roundKey        (roundKey),
        .round           (round),
        .invSBoxRequest  (invSBoxRequest),
        .invSBoxResponse (invSBoxResponse),
        .newBlock        (newBlock),
        .ready           (ready)
    );

    inv_sub_box uSbox (
        .request  (invSBoxRequest),
        .response (invSBoxResponse)
    );

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] pt;
        int           start;
    } exp_t;

    exp_t         q[$];
    int           tests = 0;
    int           fails = 0;
    int           cyc = 0;
    int           d;
    logic [127:0] lastPt = '0;
    logic [127:0] keys [2][11];
    logic         keySel = 1'b0;
    logic         jobKey = 1'b0;

    // KeyGen model: key set latched on the accepted next, indexed by round.
    always_comb begin
        roundKey = '0;
        if (round <= 4'd10) roundKey = keys[jobKey][round];
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset && ready && next) jobKey <= keySel;
    end

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box from first principles: x^254 then the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] v;
        v = x;
        for (int i = 0; i < 253; i++) v = gm(v, x);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    task automatic expand(input int set, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i - 1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end
            w[i] = w[i - 4] ^ t;
        end
        for (int r = 0; r < 11; r++) keys[set][r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    // Monitor: per-cycle round/ready/request model plus result pop on completion.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (q.size() > 0 && cyc >= q[0].start) begin
                d = cyc - q[0].start;
                if (d == 0) check("round_init", 128'(round), 128'd10);
                else if (d <= 50) check("round_seq", 128'(round), 128'(9 - (d - 1) / 5));
                else check("round_done", 128'(round), 128'd0);
                if (d == 0 || d >= 51 || (d - 1) % 5 == 4) check("req_zero", 128'(invSBoxRequest), 128'd0);
                check("ready", 128'(ready), (d >= 51) ? 128'd1 : 128'd0);
                if (d == 51) begin
                    check("result", newBlock, q[0].pt);
                    lastPt = q[0].pt;
                    void'(q.pop_front());
                end else begin
                    check("hold", newBlock, lastPt);
                end
            end else begin
                check("idle_round", 128'(round), 128'd0);
                check("idle_ready", 128'(ready), 128'd1);
                check("idle_req", 128'(invSBoxRequest), 128'd0);
                check("hold", newBlock, lastPt);
            end
        end
    end

    task automatic issue(input logic [127:0] ct, input logic [127:0] pt, input logic ks);
        block  = ct;
        keySel = ks;
        next   = 1'b1;
        q.push_back('{pt: pt, start: cyc + 1});
        @(negedge clk);
        next = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (q.size() > 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL timeout %s: %0d results outstanding, expected 0", name, q.size());
            q.delete();
        end
    endtask

    initial begin
        int s1;
        int guard;
        reset = 1'b0;
        next  = 1'b0;
        block = '0;
        expand(0, KEY_C1);
        expand(1, KEY_B);
        #12;
        check("rst_ready", 128'(ready), 128'd1);
        check("rst_newBlock", newBlock, 128'd0);
        check("rst_round", 128'(round), 128'd0);
        check("rst_req", 128'(invSBoxRequest), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        issue(CT_C1, PT_C1, 1'b0);
        waitDone("c1");
        issue(CT_B, PT_B, 1'b1);
        waitDone("appB");

        // Busy next: different block arrives 20 cycles in and must be ignored.
        issue(CT_C1, PT_C1, 1'b0);
        repeat (19) @(negedge clk);
        block  = CT_B;
        keySel = 1'b1;
        next   = 1'b1;
        @(negedge clk);
        next   = 1'b0;
        waitDone("busy");

        // Reset 30 cycles into a job drops it; a fresh job then completes.
        issue(CT_B, PT_B, 1'b1);
        repeat (29) @(negedge clk);
        reset = 1'b0;
        q.delete();
        lastPt = '0;
        #1;
        check("midrst_ready", 128'(ready), 128'd1);
        check("midrst_newBlock", newBlock, 128'd0);
        check("midrst_round", 128'(round), 128'd0);
        check("midrst_req", 128'(invSBoxRequest), 128'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(CT_C1, PT_C1, 1'b0);
        waitDone("after_reset");

        // Back-to-back with next held high: App. B then C.1, 52 cycles apart.
        @(negedge clk);
        block  = CT_B;
        keySel = 1'b1;
        next   = 1'b1;
        s1     = cyc + 1;
        q.push_back('{pt: PT_B, start: s1});
        q.push_back('{pt: PT_C1, start: s1 + 52});
        @(negedge clk);
        block  = CT_C1;
        keySel = 1'b0;
        guard  = 0;
        while (cyc < s1 + 52 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        next = 1'b0;
        waitDone("b2b");

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion by 200000");
        $fatal(1);
    end

endmodule
